// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_cfg
// Brief  : Configurable UART receiver with majority-vote line filtering,
//          parity/frame checking and break detection.
// Rev    : 1.0
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_serial,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] C_CNT_LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_CNT_HALF      = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] C_IDX_DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] C_IDX_STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_DONE      = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [2:0]             vote_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop_low_q, stop_low_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   break_q, break_d;

    logic w_line;
    logic w_cnt_end;
    logic w_par_xor;
    logic w_par_err;
    logic w_brk_cand;

    assign w_line     = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
    assign w_cnt_end  = (cnt_q == C_CNT_LAST);
    assign w_par_xor  = (^shift_q) ^ par_bit_q;
    assign w_par_err  = (PARITY == 1) ? ~w_par_xor : ((PARITY == 2) ? w_par_xor : 1'b0);
    assign w_brk_cand = (shift_q == '0) && ((PARITY == 0) || !par_bit_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        stop_low_d   = stop_low_q;
        rx_valid_d   = 1'b0;
        break_d      = 1'b0;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                stop_low_d = 1'b0;
                if (!w_line) state_d = S_START;
            end
            S_START: begin
                // A start that is not still low at mid-bit is treated as a glitch.
                if (cnt_q == C_CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = w_line ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_end) begin
                    cnt_d   = '0;
                    shift_d = {w_line, shift_q[DATA_BITS-1:1]};
                    if (idx_q == C_IDX_DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY == 0) ? S_STOP : S_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_cnt_end) begin
                    cnt_d     = '0;
                    par_bit_d = w_line;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_cnt_end) begin
                    cnt_d = '0;
                    // Break is decided on the first stop bit; remaining stop bits are not awaited.
                    if ((idx_q == '0) && w_brk_cand && !w_line) begin
                        break_d = 1'b1;
                        idx_d   = '0;
                        state_d = S_WAIT_HIGH;
                    end else begin
                        stop_low_d = stop_low_q | ~w_line;
                        if (idx_q == C_IDX_STOP_LAST) begin
                            idx_d        = '0;
                            rx_valid_d   = 1'b1;
                            rx_data_d    = shift_q;
                            parity_err_d = w_par_err;
                            frame_err_d  = stop_low_q | ~w_line;
                            state_d      = S_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = frame_err_q ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (w_line) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            vote_q       <= 3'b111;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_low_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_serial};
            vote_q       <= {vote_q[1:0], sync_q[1]};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            stop_low_q   <= stop_low_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_cfg
// Brief  : Self-checking bench: 8N1 receiver and 8E2 receiver driven with
//          directed and random frames, compared against a frame-level model.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_cfg;
    localparam int CPB0 = 87;
    localparam int CPB1 = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0   = 1'b1;
    logic       rx1   = 1'b1;
    logic       valid [2];
    logic [7:0] data  [2];
    logic       perr  [2];
    logic       ferr  [2];
    logic       brk   [2];
    logic       busy  [2];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_serial(rx0),
        .rx_valid(valid[0]), .rx_data(data[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .break_det(brk[0]), .rx_busy(busy[0])
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_serial(rx1),
        .rx_valid(valid[1]), .rx_data(data[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .break_det(brk[1]), .rx_busy(busy[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt [2] = '{0, 0};
    int bcnt [2] = '{0, 0};
    int vcyc [2] = '{0, 0};

    // Frame-level reference state
    int         exp_v    [2] = '{0, 0};
    int         exp_b    [2] = '{0, 0};
    logic [7:0] exp_data [2] = '{8'h00, 8'h00};
    logic       exp_perr [2] = '{1'b0, 1'b0};
    logic       exp_ferr [2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (valid[d]) begin
                vcnt[d] <= vcnt[d] + 1;
                vcyc[d] <= cyc;
            end
            if (brk[d]) bcnt[d] <= bcnt[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic v, input int ncyc);
        if (d == 0) rx0 = v;
        else        rx1 = v;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic check_state(input int d, input string tag);
        check({tag, "_vcnt"}, vcnt[d], exp_v[d]);
        check({tag, "_bcnt"}, bcnt[d], exp_b[d]);
        check({tag, "_data"}, data[d], exp_data[d]);
        check({tag, "_perr"}, perr[d], exp_perr[d]);
        check({tag, "_ferr"}, ferr[d], exp_ferr[d]);
        check({tag, "_busy"}, busy[d], 0);
    endtask

    // Sends start + data (LSB first) + [even parity ^ flip] + stop bits, optional
    // low hold after the stop bits and a one-cycle glitch inside data bit gbit.
    task automatic send_frame(input int d, input logic [7:0] dv, input logic flip_par,
                              input logic [1:0] stop, input int hold_low, input int gbit,
                              input string tag);
        int          cpb;
        int          nstop;
        int          n;
        int          t0;
        int          lat_exp;
        logic        par;
        logic        is_brk;
        logic [11:0] bits;
        cpb   = (d == 0) ? CPB0 : CPB1;
        nstop = (d == 0) ? 1 : 2;
        par   = (d == 1) ? ((^dv) ^ flip_par) : 1'b0;
        bits  = '0;
        n     = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = dv[i]; n++; end
        if (d == 1) begin bits[n] = par; n++; end
        for (int s = 0; s < nstop; s++) begin bits[n] = stop[s]; n++; end

        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            if (k == gbit + 1) begin
                drive(d, bits[k], cpb / 2);
                drive(d, ~bits[k], 1);
                drive(d, bits[k], cpb - cpb / 2 - 1);
            end else begin
                drive(d, bits[k], cpb);
            end
        end
        if (hold_low > 0) begin
            drive(d, 1'b0, hold_low);
            check({tag, "_busy_hold"}, busy[d], 1);
        end
        drive(d, 1'b1, 2 * cpb);

        is_brk = (dv == 8'h00) && ((d == 0) || !par) && !stop[0];
        if (is_brk) begin
            exp_b[d]++;
        end else begin
            exp_v[d]++;
            exp_data[d] = dv;
            exp_perr[d] = (d == 1) ? ((^dv) ^ par) : 1'b0;
            exp_ferr[d] = !stop[0] || ((nstop == 2) && !stop[1]);
            // 2-flop sync + 2 voter samples, one IDLE cycle, half bit, then one bit per sample
            lat_exp = 6 + (cpb - 1) / 2 + cpb * (n - 1);
            check({tag, "_lat"}, vcyc[d] - t0, lat_exp);
        end
        check_state(d, tag);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid[0], 0);
        check("rst_data",  data[0],  0);
        check("rst_perr",  perr[0],  0);
        check("rst_ferr",  ferr[0],  0);
        check("rst_brk",   brk[0],   0);
        check("rst_busy",  busy[0],  0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(0, 8'hA5, 1'b0, 2'b11, 0, -1, "a5");

        drive(0, 1'b0, 20);
        drive(0, 1'b1, 2 * CPB0);
        check_state(0, "glitch_start");

        send_frame(1, 8'h03, 1'b1, 2'b11, 0, -1, "e03_bad");
        send_frame(1, 8'h03, 1'b0, 2'b11, 0, -1, "e03_ok");

        send_frame(0, 8'h55, 1'b0, 2'b10, 3 * CPB0, -1, "ferr55");
        send_frame(0, 8'h3C, 1'b0, 2'b11, 0, -1, "clean3c");

        drive(0, 1'b0, 12 * CPB0);
        drive(0, 1'b1, 2 * CPB0);
        exp_b[0]++;
        check_state(0, "break");

        send_frame(0, 8'hF0, 1'b0, 2'b11, 0, 0, "glitch_f0");
        send_frame(1, 8'hA0, 1'b0, 2'b11, 0, 2, "glitch_a0");
        send_frame(1, 8'h5A, 1'b0, 2'b01, 0, -1, "e_stop2");

        // Reset in the middle of bit 4 of 0xFF
        drive(0, 1'b0, CPB0);
        drive(0, 1'b1, 4 * CPB0 + CPB0 / 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data0", data[0], 0);
        check("mid_rst_data1", data[1], 0);
        check("mid_rst_ferr0", ferr[0], 0);
        check("mid_rst_busy0", busy[0], 0);
        exp_data = '{8'h00, 8'h00};
        exp_perr = '{1'b0, 1'b0};
        exp_ferr = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * CPB0);
        check_state(0, "post_rst");
        send_frame(0, 8'h81, 1'b0, 2'b11, 0, -1, "after_rst81");

        for (int i = 0; i < 10; i++) begin
            logic [7:0] dv;
            logic       sb;
            dv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(0, dv, 1'b0, {1'b1, sb}, 0, -1, "rnd0");
        end
        for (int i = 0; i < 30; i++) begin
            logic [7:0] dv;
            logic [1:0] sb;
            logic       fp;
            dv    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            fp    = ($urandom_range(0, 3) == 0);
            sb[0] = ($urandom_range(0, 4) != 0);
            sb[1] = ($urandom_range(0, 4) != 0);
            send_frame(1, dv, fp, sb, 0, -1, "rnd1");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
